// File: rtl/fp_mult_seq_ctrl.sv
// Sequential single-precision multiplier: shift-and-add mantissa loop over one
// shared 25-bit adder, exponent handled by one shared 10-bit adder.
module fp_mult_seq_ctrl #(
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned ACC_W  = 25;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MANT_W - 1);
  localparam logic [EXP_W-1:0] EXP_K     = EXP_W'((1024 - EXP_BIAS) % 1024);
  localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

  typedef enum logic [2:0] {S_IDLE, S_EXP, S_MUL, S_NORM, S_DONE} state_t;

  state_t            state_q;
  logic              sign_q;
  logic [7:0]        ea_q, eb_q;
  logic [MANT_W-1:0] ma_q, mb_q, q_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [EXP_W-1:0]  e_q;
  logic              spec_q;
  logic [31:0]       spec_res_q;
  logic              in_ready_q, out_valid_q, busy_q;
  logic [31:0]       result_q;

  logic              spec_d;
  logic [31:0]       spec_res_d;
  logic [ACC_W-1:0]  sum_d;
  logic [EXP_W-1:0]  exp_x, exp_y, exp_k, exp_d;
  logic [22:0]       frac_d;
  logic [31:0]       norm_res_d;

  // Operand classification on the incoming pair; NaN and inf*0 win over inf, inf over zero.
  always_comb begin
    logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    a_max  = &a[30:23];
    b_max  = &b[30:23];
    a_nan  = a_max & (|a[22:0]);
    b_nan  = b_max & (|b[22:0]);
    a_inf  = a_max & ~(|a[22:0]);
    b_inf  = b_max & ~(|b[22:0]);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    sgn    = a[31] ^ b[31];
    spec_d     = 1'b1;
    spec_res_d = 32'h0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res_d = QNAN;
    end else if (a_inf || b_inf) begin
      spec_res_d = {sgn, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      spec_res_d = {sgn, 31'h0};
    end else begin
      spec_d = 1'b0;
    end
  end

  assign sum_d = {1'b0, acc_q[MANT_W-1:0]} + {1'b0, ma_q};

  // Shared exponent adder: biased sum in EXP, normalisation increment otherwise.
  always_comb begin
    exp_x = e_q;
    exp_y = '0;
    exp_k = {{(EXP_W-1){1'b0}}, acc_q[MANT_W-1]};
    if (state_q == S_EXP) begin
      exp_x = {2'b00, ea_q};
      exp_y = {2'b00, eb_q};
      exp_k = EXP_K;
    end
    exp_d = exp_x + exp_y + exp_k;
  end

  // Product P = {acc[23:0], q}; P[47] selects which 23 bits form the fraction.
  always_comb begin
    frac_d = acc_q[MANT_W-1] ? acc_q[22:0] : {acc_q[21:0], q_q[MANT_W-1]};
    if ($signed(exp_d) >= $signed(10'd255)) begin
      norm_res_d = {sign_q, 8'hFF, 23'h0};
    end else if ($signed(exp_d) <= $signed(10'd0)) begin
      norm_res_d = {sign_q, 31'h0};
    end else begin
      norm_res_d = {sign_q, exp_d[7:0], frac_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      q_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      e_q         <= '0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            sign_q     <= a[31] ^ b[31];
            ma_q       <= {1'b1, a[22:0]};
            mb_q       <= {1'b1, b[22:0]};
            ea_q       <= a[30:23];
            eb_q       <= b[30:23];
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_EXP;
          end
        end
        S_EXP: begin
          if (spec_q) begin
            result_q    <= spec_res_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            e_q     <= exp_d;
            acc_q   <= '0;
            q_q     <= mb_q;
            cnt_q   <= '0;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (q_q[0]) begin
            acc_q <= {1'b0, sum_d[ACC_W-1:1]};
            q_q   <= {sum_d[0], q_q[MANT_W-1:1]};
          end else begin
            acc_q <= {1'b0, acc_q[ACC_W-1:1]};
            q_q   <= {acc_q[0], q_q[MANT_W-1:1]};
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_q <= S_NORM;
        end
        S_NORM: begin
          e_q         <= exp_d;
          result_q    <= norm_res_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Directed bench for fp_mult_seq_ctrl: results, latency, back-pressure and reset.
module tb_fp_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  fp_mult_seq_ctrl #(.EXP_BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Issue one operation; lat counts edges after the accept edge until out_valid, -1 on timeout.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit retire,
                        output logic [31:0] res, output int lat, output bit stat_ok);
    int w;
    w = 0; lat = -1; stat_ok = 1'b1;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av; b = 32'h0;
    for (int i = 1; i <= 100; i++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) stat_ok = 1'b0;
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = i; break; end
    end
    res = result;
    if (retire && lat > 0) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_normal();
    logic [31:0] r; int l; bit s;
    run_op(32'h3F800000, 32'h3F800000, 1'b1, r, l, s);
    checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL normal_result got %h exp 3f800000", r); end
    checks++; if (l != 26) begin errors++; $display("FAIL normal_latency got %0d exp 26", l); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL normal_busy_inready got %b exp 1", s); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL normal_retire_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL normal_retire_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_norm_sign();
    logic [31:0] r; int l; bit s;
    run_op(32'h3FC00000, 32'h3FC00000, 1'b1, r, l, s);
    checks++; if (r !== 32'h40100000) begin errors++; $display("FAIL norm_p47_result got %h exp 40100000", r); end
    checks++; if (l != 26) begin errors++; $display("FAIL norm_p47_latency got %0d exp 26", l); end
    run_op(32'hC0000000, 32'h40400000, 1'b1, r, l, s);
    checks++; if (r !== 32'hC0C00000) begin errors++; $display("FAIL sign_result got %h exp c0c00000", r); end
    checks++; if (l != 26) begin errors++; $display("FAIL sign_latency got %0d exp 26", l); end
  endtask

  task automatic test_ovf_unf();
    logic [31:0] r; int l; bit s;
    run_op(32'h7F000000, 32'h7F000000, 1'b1, r, l, s);
    checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL overflow_result got %h exp 7f800000", r); end
    checks++; if (l != 26) begin errors++; $display("FAIL overflow_latency got %0d exp 26", l); end
    run_op(32'h00800000, 32'h00800000, 1'b1, r, l, s);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL underflow_result got %h exp 00000000", r); end
    checks++; if (l != 26) begin errors++; $display("FAIL underflow_latency got %0d exp 26", l); end
  endtask

  task automatic test_specials();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] ve [4];
    logic [31:0] r; int l; bit s;
    va[0] = 32'h00000000; vb[0] = 32'h40400000; ve[0] = 32'h00000000;
    va[1] = 32'h7F800000; vb[1] = 32'h00000000; ve[1] = 32'h7FC00000;
    va[2] = 32'hFF800000; vb[2] = 32'h40000000; ve[2] = 32'hFF800000;
    va[3] = 32'h7FC00001; vb[3] = 32'h3F800000; ve[3] = 32'h7FC00000;
    for (int k = 0; k < 4; k++) begin
      run_op(va[k], vb[k], 1'b1, r, l, s);
      checks++; if (r !== ve[k]) begin errors++; $display("FAIL special%0d_result got %h exp %h", k, r, ve[k]); end
      checks++; if (l != 1) begin errors++; $display("FAIL special%0d_latency got %0d exp 1", k, l); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int l; bit s;
    out_ready = 1'b0;
    run_op(32'h3FC00000, 32'h3FC00000, 1'b0, r, l, s);
    checks++; if (r !== 32'h40100000) begin errors++; $display("FAIL bp_result got %h exp 40100000", r); end
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy, result} !== {1'b1, 1'b0, 1'b1, 32'h40100000}) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b r=%b busy=%b res=%h exp v=1 r=0 busy=1 res=40100000",
                 k, out_valid, in_ready, busy, result);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_valid_drop got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_no_accept got busy=%b exp 0", busy); end
    checks++; if (result !== 32'h40100000) begin errors++; $display("FAIL hs_result_hold got %h exp 40100000", result); end
    run_op(32'h3F800000, 32'h40000000, 1'b1, r, l, s);
    checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL b2b_result got %h exp 40000000", r); end
    checks++; if (l != 26) begin errors++; $display("FAIL b2b_latency got %0d exp 26", l); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int l; bit s; bit seen;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    a = 32'h3FC00000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h exp 00000000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse got activity=%b exp 0", seen); end
    run_op(32'h40400000, 32'h40400000, 1'b1, r, l, s);
    checks++; if (r !== 32'h41100000) begin errors++; $display("FAIL rstmid_next_result got %h exp 41100000", r); end
    checks++; if (l != 26) begin errors++; $display("FAIL rstmid_next_latency got %0d exp 26", l); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_norm_sign();
    test_ovf_unf();
    test_specials();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_seq_ctrl.md
Name: fp_mult_seq_ctrl

Overview:
- Sequential IEEE-754 single-precision multiplier controller.
- Uses one shared adder_25bit for 24 shift-and-add mantissa iterations and one adder_10bit for the exponent sum.
- Ready/valid handshake on input and output; one operation in flight; result rounding is truncation; subnormal inputs are flushed to zero.
- Sits between operand registers and the result writeback of the FP calculator.

Parameters:
- EXP_BIAS, 127, exponent bias. The exponent adder constant is (1024 - EXP_BIAS) mod 1024, i.e. 10'h381 by default.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  controller can accept operands
- a  input  32  operand A, IEEE-754 single
- b  input  32  operand B, IEEE-754 single
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  product, IEEE-754 single
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, iteration counter=0, all datapath registers=0.
- States: IDLE, EXP, MUL, NORM, DONE. in_ready=1 only in IDLE.
- IDLE: on in_valid&&in_ready, capture:
  - sign = a[31]^b[31];
  - ma={1,a[22:0]}, mb={1,b[22:0]}, ea=a[30:23], eb=b[30:23].
- Special check at capture, priority high to low:
  - any NaN (exp=255, frac!=0), or inf×zero → result=32'h7FC00000;
  - any inf → {sign,8'hFF,23'h0};
  - any exp=0 → {sign,31'h0}.
  - Special cases go directly to DONE (out_valid 1 cycle after the accept edge). Otherwise → EXP.
- EXP (1 cycle):
  - e = {2'b0,ea} + {2'b0,eb} + 10'h381 via adder_10bit; Cout discarded; e is a 10-bit two's-complement value.
  - Clear A (25 bits), Q=mb, counter=0. → MUL.
- MUL (exactly 24 cycles):
  - Each cycle: sum = adder_25bit({1'b0,A[23:0]}, {1'b0,ma}).
  - If Q[0]: {A,Q} = {sum,Q}>>1, else {A,Q}>>1.
  - counter++. After counter reaches 23 → NORM.
  - Final 48-bit product P = {A[23:0],Q}.
- NORM (1 cycle):
  - If P[47]: frac=P[46:24], e=e+1 (adder_10bit). Else frac=P[45:23].
  - If e signed ≥255 → {sign,8'hFF,23'h0} (overflow to inf).
  - If e signed ≤0 → {sign,31'h0} (underflow flush).
  - Else {sign,e[7:0],frac}.
  - → DONE.
- DONE: out_valid=1, result stable until out_valid&&out_ready, then out_valid=0 and → IDLE on that edge. in_ready returns to 1 the cycle after the handshake.
- Normal latency: out_valid rises 26 cycles after the accept edge (EXP 1 + MUL 24 + NORM 1).
- Input changes on a/b while busy are ignored.
- Back-pressure: out_ready=0 holds DONE indefinitely; no new operand is accepted.
- Reset mid-operation (any state) returns to the reset values immediately; the partial product is discarded and no out_valid pulse follows.
- in_valid asserted during the same cycle as the output handshake is not accepted; it is accepted on the next cycle in IDLE.
- result holds its last value after the handshake until the next DONE.

Test Plan:
- Normal case: a=3F800000, b=3F800000 → result=3F800000; out_valid exactly 26 cycles after the accept edge; in_ready=0 throughout.
- Normalization and sign:
  - a=3FC00000, b=3FC00000 → 40100000 (P[47]=1 path).
  - a=C0000000, b=40400000 → C0C00000.
- Overflow and underflow:
  - a=7F000000, b=7F000000 → 7F800000.
  - a=00800000, b=00800000 → 00000000, via the full 26-cycle path.
- Specials: each result arrives with out_valid 1 cycle after accept.
  - a=00000000, b=40400000 → 00000000.
  - a=7F800000, b=00000000 → 7FC00000.
  - a=FF800000, b=40000000 → FF800000.
  - a=7FC00001, b=3F800000 → 7FC00000.
- Handshake: hold out_ready=0 for 10 cycles after out_valid → result stable, in_valid ignored. Then out_ready=1 → out_valid drops on the next edge, and in_ready=1 on the following cycle. A back-to-back second operation 3F800000×40000000 → 40000000.
- Reset: assert rst_n=0 during MUL cycle 10 → all outputs at reset values immediately. Release reset, then issue 40400000×40400000 → 41100000 with correct 26-cycle latency.
